// File: rtl/systolic_feeder_4x4.sv
`default_nettype none
// ============================================================================
//  Module   : systolic_feeder_4x4
//  Purpose  : Holds two 4x4 int8 matrices (A, B), streams them with diagonal
//             skew into an external output-stationary 4x4 systolic array,
//             waits for the array to drain, then streams out the 16 int32
//             accumulators over a valid/ready interface.
//  Options  : FEEDER_PERF_CNT_EN - adds a 16-bit saturating busy-cycle counter
//             on output cycle_count.
//  Revision : 1.0 - initial release
// ============================================================================
module systolic_feeder_4x4 #(
  parameter int DRAIN_CYCLES = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic        ld_sel,
  input  logic [3:0]  ld_addr,
  input  logic [7:0]  ld_data,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        clear,
  output logic [7:0]  a1,
  output logic [7:0]  a2,
  output logic [7:0]  a3,
  output logic [7:0]  a4,
  output logic [7:0]  b1,
  output logic [7:0]  b2,
  output logic [7:0]  b3,
  output logic [7:0]  b4,
  input  logic [31:0] c11, c12, c13, c14,
  input  logic [31:0] c21, c22, c23, c24,
  input  logic [31:0] c31, c32, c33, c34,
  input  logic [31:0] c41, c42, c43, c44,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [3:0]  res_idx,
  output logic        res_last
`ifdef FEEDER_PERF_CNT_EN
  ,
  output logic [15:0] cycle_count
`endif
);

  localparam logic [2:0]  c_IDLE       = 3'd0;
  localparam logic [2:0]  c_CLEAR      = 3'd1;
  localparam logic [2:0]  c_FEED       = 3'd2;
  localparam logic [2:0]  c_DRAIN      = 3'd3;
  localparam logic [2:0]  c_READ       = 3'd4;
  localparam logic [15:0] c_FEED_LAST  = 16'd6;
  localparam logic [15:0] c_DRAIN_LAST = 16'(DRAIN_CYCLES - 1);

  logic [2:0]  r_state;
  logic [15:0] r_cnt;       // feed step in FEED, drain cycle in DRAIN
  logic [3:0]  r_idx;
  logic        r_done;
  logic        r_clear;
  logic [7:0]  r_a [4];
  logic [7:0]  r_b [4];
  logic [7:0]  r_mem_a [16];
  logic [7:0]  r_mem_b [16];

  logic [2:0]  w_nstate;
  logic [15:0] w_ncnt;
  logic [7:0]  w_a_feed [4];
  logic [7:0]  w_b_feed [4];
  logic [31:0] w_c_sel;
  logic        w_xfer;

  assign ld_ready = (r_state == c_IDLE);
  assign busy     = (r_state != c_IDLE);
  assign w_xfer   = (r_state == c_READ) && res_ready;

  // Next state and step counter; array-side registers are loaded from these
  // so each state's values appear on the edge that enters it.
  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt;
    case (r_state)
      c_IDLE: begin
        if (start) w_nstate = c_CLEAR;
      end
      c_CLEAR: begin
        w_nstate = c_FEED;
        w_ncnt   = 16'd0;
      end
      c_FEED: begin
        if (r_cnt == c_FEED_LAST) begin
          w_nstate = (DRAIN_CYCLES == 0) ? c_READ : c_DRAIN;
          w_ncnt   = 16'd0;
        end else begin
          w_ncnt = r_cnt + 16'd1;
        end
      end
      c_DRAIN: begin
        if (r_cnt == c_DRAIN_LAST) begin
          w_nstate = c_READ;
          w_ncnt   = 16'd0;
        end else begin
          w_ncnt = r_cnt + 16'd1;
        end
      end
      c_READ: begin
        if (res_ready && (r_idx == 4'd15)) w_nstate = c_IDLE;
      end
      default: w_nstate = c_IDLE;
    endcase
  end

  // Lane i (row stream a, column stream b) is skewed by i steps: at step t it
  // carries element k = t - i, or zero outside 0..3.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [2:0] w_k;
    logic       w_on;
    assign w_k          = w_ncnt[2:0] - 3'(gi);
    assign w_on         = (w_ncnt[2:0] >= 3'(gi)) && (w_k <= 3'd3);
    assign w_a_feed[gi] = w_on ? r_mem_a[{2'(gi), w_k[1:0]}] : 8'd0;
    assign w_b_feed[gi] = w_on ? r_mem_b[{w_k[1:0], 2'(gi)}] : 8'd0;
  end

  // Control state, result index and registered array-side outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_IDLE;
      r_cnt   <= 16'd0;
      r_idx   <= 4'd0;
      r_done  <= 1'b0;
      r_clear <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        r_a[k] <= 8'd0;
        r_b[k] <= 8'd0;
      end
    end else begin
      r_state <= w_nstate;
      r_cnt   <= w_ncnt;
      r_clear <= (w_nstate == c_CLEAR);
      r_done  <= w_xfer && (r_idx == 4'd15);
      if (w_xfer) r_idx <= r_idx + 4'd1;  // wraps to 0 after the last result
      for (int k = 0; k < 4; k++) begin
        r_a[k] <= (w_nstate == c_FEED) ? w_a_feed[k] : 8'd0;
        r_b[k] <= (w_nstate == c_FEED) ? w_b_feed[k] : 8'd0;
      end
    end
  end

  // Matrix storage; writes only accepted while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 16; k++) begin
        r_mem_a[k] <= 8'd0;
        r_mem_b[k] <= 8'd0;
      end
    end else if (ld_valid && ld_ready) begin
      if (ld_sel) r_mem_b[ld_addr] <= ld_data;
      else        r_mem_a[ld_addr] <= ld_data;
    end
  end

  // Result mux: accumulator picked straight from the array by result index.
  always_comb begin
    w_c_sel = 32'd0;
    case (r_idx)
      4'd0:  w_c_sel = c11;
      4'd1:  w_c_sel = c12;
      4'd2:  w_c_sel = c13;
      4'd3:  w_c_sel = c14;
      4'd4:  w_c_sel = c21;
      4'd5:  w_c_sel = c22;
      4'd6:  w_c_sel = c23;
      4'd7:  w_c_sel = c24;
      4'd8:  w_c_sel = c31;
      4'd9:  w_c_sel = c32;
      4'd10: w_c_sel = c33;
      4'd11: w_c_sel = c34;
      4'd12: w_c_sel = c41;
      4'd13: w_c_sel = c42;
      4'd14: w_c_sel = c43;
      4'd15: w_c_sel = c44;
      default: w_c_sel = 32'd0;
    endcase
  end

  assign res_valid = (r_state == c_READ);
  assign res_data  = res_valid ? w_c_sel : 32'd0;
  assign res_idx   = r_idx;
  assign res_last  = res_valid && (r_idx == 4'd15);
  assign done      = r_done;
  assign clear     = r_clear;
  assign a1 = r_a[0];
  assign a2 = r_a[1];
  assign a3 = r_a[2];
  assign a4 = r_a[3];
  assign b1 = r_b[0];
  assign b2 = r_b[1];
  assign b3 = r_b[2];
  assign b4 = r_b[3];

`ifdef FEEDER_PERF_CNT_EN
  logic [15:0] r_cycle_count;

  // Busy-cycle counter: zeroed on an accepted start, saturating, held in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cycle_count <= 16'd0;
    end else if ((r_state == c_IDLE) && start) begin
      r_cycle_count <= 16'd0;
    end else if ((r_state != c_IDLE) && (r_cycle_count != 16'hFFFF)) begin
      r_cycle_count <= r_cycle_count + 16'd1;
    end
  end

  assign cycle_count = r_cycle_count;
`else
  // Busy-cycle counter is not present in this build.
`endif

endmodule
`default_nettype wire

// File: tb/tb_systolic_feeder_4x4.sv
`default_nettype none
// ============================================================================
//  Module   : tb_systolic_feeder_4x4
//  Purpose  : Bench for systolic_feeder_4x4 with a behavioural 4x4
//             output-stationary array driven by the feeder's streams; expected
//             products come from a reference matrix multiply.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_feeder_4x4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic        ld_sel = 1'b0;
  logic [3:0]  ld_addr = 4'd0;
  logic [7:0]  ld_data = 8'd0;
  logic        start = 1'b0;
  logic        busy, done, clear;
  logic [7:0]  a1, a2, a3, a4, b1, b2, b3, b4;
  logic [31:0] c11, c12, c13, c14, c21, c22, c23, c24;
  logic [31:0] c31, c32, c33, c34, c41, c42, c43, c44;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [31:0] res_data;
  logic [3:0]  res_idx;
  logic        res_last;
`ifdef FEEDER_PERF_CNT_EN
  logic [15:0] cycle_count;
`endif

  always #5 clk = ~clk;

  systolic_feeder_4x4 #(.DRAIN_CYCLES(10)) dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_sel(ld_sel),
    .ld_addr(ld_addr), .ld_data(ld_data),
    .start(start), .busy(busy), .done(done), .clear(clear),
    .a1(a1), .a2(a2), .a3(a3), .a4(a4),
    .b1(b1), .b2(b2), .b3(b3), .b4(b4),
    .c11(c11), .c12(c12), .c13(c13), .c14(c14),
    .c21(c21), .c22(c22), .c23(c23), .c24(c24),
    .c31(c31), .c32(c32), .c33(c33), .c34(c34),
    .c41(c41), .c42(c42), .c43(c43), .c44(c44),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_idx(res_idx), .res_last(res_last)
`ifdef FEEDER_PERF_CNT_EN
    , .cycle_count(cycle_count)
`endif
  );

  // ---------------- behavioural systolic array ----------------
  logic signed [7:0]  a_in [4];
  logic signed [7:0]  b_in [4];
  logic signed [7:0]  ap [4][4];
  logic signed [7:0]  bp [4][4];
  logic signed [31:0] acc [4][4];
  logic signed [7:0]  m_ina, m_inb;

  assign a_in[0] = a1; assign a_in[1] = a2; assign a_in[2] = a3; assign a_in[3] = a4;
  assign b_in[0] = b1; assign b_in[1] = b2; assign b_in[2] = b3; assign b_in[3] = b4;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          ap[i][j]  <= 8'sd0;
          bp[i][j]  <= 8'sd0;
          acc[i][j] <= 32'sd0;
        end
    end else begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          if (j == 0) m_ina = a_in[i]; else m_ina = ap[i][j-1];
          if (i == 0) m_inb = b_in[j]; else m_inb = bp[i-1][j];
          ap[i][j]  <= m_ina;
          bp[i][j]  <= m_inb;
          acc[i][j] <= clear ? 32'sd0 : acc[i][j] + 32'(m_ina) * 32'(m_inb);
        end
    end
  end

  assign c11 = acc[0][0]; assign c12 = acc[0][1]; assign c13 = acc[0][2]; assign c14 = acc[0][3];
  assign c21 = acc[1][0]; assign c22 = acc[1][1]; assign c23 = acc[1][2]; assign c24 = acc[1][3];
  assign c31 = acc[2][0]; assign c32 = acc[2][1]; assign c33 = acc[2][2]; assign c34 = acc[2][3];
  assign c41 = acc[3][0]; assign c42 = acc[3][1]; assign c43 = acc[3][2]; assign c44 = acc[3][3];

  // ---------------- scoreboard and helpers ----------------
  typedef struct {
    logic [31:0] d;
    logic [3:0]  idx;
    logic        last;
  } exp_t;

  exp_t sb[$];
  int   ma [16];
  int   mb [16];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load(input logic sel, input logic [3:0] addr, input logic [7:0] data);
    ld_valid = 1'b1; ld_sel = sel; ld_addr = addr; ld_data = data;
    @(negedge clk);
    ld_valid = 1'b0;
    if (sel) mb[addr] = int'($signed(data));
    else     ma[addr] = int'($signed(data));
  endtask

  task automatic push_expected();
    int s;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        s = 0;
        for (int k = 0; k < 4; k++) s += ma[r*4+k] * mb[k*4+c];
        sb.push_back('{d: 32'(s), idx: 4'(r*4+c), last: ((r*4+c) == 15)});
      end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_read();
    int to;
    to = 0;
    while (!res_valid && to < 60) begin
      @(negedge clk);
      to++;
    end
    check("read_reached", {31'd0, res_valid}, 32'd1);
  endtask

  // Drains 16 results; with bpress, holds res_ready low 5 cycles at index 3.
  task automatic collect(input bit bpress);
    exp_t e;
    int   to;
    for (int n = 0; n < 16; n++) begin
      to = 0;
      while (!res_valid && to < 20) begin
        @(negedge clk);
        to++;
      end
      e = sb.pop_front();
      if (bpress && n == 3) begin
        res_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check("bp_data", res_data, e.d);
          check("bp_idx", {28'd0, res_idx}, {28'd0, e.idx});
        end
        res_ready = 1'b1;
      end
      check("res_valid", {31'd0, res_valid}, 32'd1);
      check("res_data", res_data, e.d);
      check("res_idx", {28'd0, res_idx}, {28'd0, e.idx});
      check("res_last", {31'd0, res_last}, {31'd0, e.last});
      @(negedge clk);
    end
  endtask

  task automatic idle_checks();
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_done", {31'd0, done}, 32'd0);
    check("idle_clear", {31'd0, clear}, 32'd0);
    check("idle_res_valid", {31'd0, res_valid}, 32'd0);
    check("idle_res_last", {31'd0, res_last}, 32'd0);
    check("idle_res_idx", {28'd0, res_idx}, 32'd0);
    check("idle_res_data", res_data, 32'd0);
    check("idle_a", {a1, a2, a3, a4}, 32'd0);
    check("idle_b", {b1, b2, b3, b4}, 32'd0);
    check("idle_ld_ready", {31'd0, ld_ready}, 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    for (int k = 0; k < 16; k++) begin ma[k] = 0; mb[k] = 0; end

    // Reset state
    #1 rst = 1'b1;
    #2 idle_checks();
    @(negedge clk);
    rst = 1'b0;

    // Run 1: A = 1..16, B = identity, res_ready held high
    for (int k = 0; k < 16; k++) load(1'b0, 4'(k), 8'(k + 1));
    for (int k = 0; k < 16; k++) load(1'b1, 4'(k), ((k / 4) == (k % 4)) ? 8'd1 : 8'd0);
    push_expected();
    do_start();
    check("r1_clear", {31'd0, clear}, 32'd1);
    check("r1_busy", {31'd0, busy}, 32'd1);
    check("r1_ld_ready", {31'd0, ld_ready}, 32'd0);
    wait_read();
    collect(1'b0);
    check("r1_done", {31'd0, done}, 32'd1);
    check("r1_idle", {31'd0, busy}, 32'd0);
`ifdef FEEDER_PERF_CNT_EN
    check("cycle_count", {16'd0, cycle_count}, 32'd34);
`endif

    // Run 2: start in the done cycle, start/load during DRAIN, backpressure
    push_expected();
    do_start();
    check("r2_clear_after_done", {31'd0, clear}, 32'd1);
    check("r2_busy", {31'd0, busy}, 32'd1);
    repeat (8) @(negedge clk);             // FEED t=0..6 then DRAIN cycle 0
    start = 1'b1;
    ld_valid = 1'b1; ld_sel = 1'b0; ld_addr = 4'd0; ld_data = 8'd99;
    check("r2_drain_ld_ready", {31'd0, ld_ready}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    ld_valid = 1'b0;
    check("r2_drain_busy", {31'd0, busy}, 32'd1);
    check("r2_drain_clear", {31'd0, clear}, 32'd0);
    wait_read();
    collect(1'b1);
    check("r2_done", {31'd0, done}, 32'd1);
    @(negedge clk);
    check("r2_done_single", {31'd0, done}, 32'd0);
    check("r2_no_restart", {31'd0, busy}, 32'd0);

    // Run 3: A all 3, B all 2 -> every result 24
    for (int k = 0; k < 16; k++) load(1'b0, 4'(k), 8'd3);
    for (int k = 0; k < 16; k++) load(1'b1, 4'(k), 8'd2);
    push_expected();
    do_start();
    wait_read();
    collect(1'b0);
    check("r3_done", {31'd0, done}, 32'd1);

    // Run 4: A row i = i, B all 1; last write coincides with start
    for (int k = 0; k < 16; k++) load(1'b0, 4'(k), 8'((k / 4) + 1));
    for (int k = 0; k < 15; k++) load(1'b1, 4'(k), 8'd1);
    ld_valid = 1'b1; ld_sel = 1'b1; ld_addr = 4'd15; ld_data = 8'd1;
    start = 1'b1;
    @(negedge clk);
    ld_valid = 1'b0;
    start = 1'b0;
    mb[15] = 1;
    push_expected();
    check("r4_clear", {31'd0, clear}, 32'd1);
    check("r4_clear_a", {a1, a2, a3, a4}, 32'd0);
    for (int t = 0; t < 7; t++) begin
      @(negedge clk);
      check("skew_a2", {24'd0, a2}, (t >= 1 && t <= 4) ? 32'd2 : 32'd0);
      check("skew_a4", {24'd0, a4}, (t >= 3) ? 32'd4 : 32'd0);
      check("skew_b3", {24'd0, b3}, (t >= 2 && t <= 5) ? 32'd1 : 32'd0);
      check("skew_clear", {31'd0, clear}, 32'd0);
    end
    wait_read();
    collect(1'b0);
    check("r4_done", {31'd0, done}, 32'd1);

    // Run 5: asynchronous reset at FEED step 2, then a run on cleared storage
    do_start();
    repeat (3) @(negedge clk);
    check("pre_rst_a2", {24'd0, a2}, 32'd2);
    #1 rst = 1'b1;
    #1 idle_checks();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 16; k++) begin ma[k] = 0; mb[k] = 0; end
    push_expected();
    do_start();
    wait_read();
    collect(1'b0);
    check("r5_done", {31'd0, done}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
